// File: rtl/wb_data_buffer.sv
// wb_data_buffer: staging buffer between the core load/store unit and the
// Wishbone master FSM.
//  - Store path: DEPTH-entry FIFO of lane-aligned write data plus byte selects.
//  - Load path: single outstanding request, lane extraction and sign/zero
//    extension of the returned bus word.
// Optional feature macro: WB_DATA_BUFFER_BYPASS_EN (empty-FIFO push bypass).
module wb_data_buffer #(
    parameter  int DATA_LENGTH = 32,
    parameter  int DEPTH       = 4,
    localparam int OFF_W       = $clog2(DATA_LENGTH/8),
    localparam int CNT_W       = $clog2(DEPTH)+1
) (
    input  logic                     clk,
    input  logic                     reset,
    // store side
    input  logic                     st_push,
    input  logic [DATA_LENGTH-1:0]   st_data,
    input  logic [OFF_W-1:0]         st_off,
    input  logic [1:0]               st_size,
    output logic                     st_full,
    output logic [CNT_W-1:0]         st_count,
    output logic                     st_err,
    output logic                     st_ovf,
    output logic                     st_valid,
    output logic [DATA_LENGTH-1:0]   bus_dat_o,
    output logic [DATA_LENGTH/8-1:0] bus_sel_o,
    input  logic                     st_ack,
    // load side
    input  logic                     ld_start,
    input  logic [OFF_W-1:0]         ld_off,
    input  logic [1:0]               ld_size,
    input  logic                     ld_unsigned,
    output logic                     ld_busy,
    input  logic [DATA_LENGTH-1:0]   bus_dat_i,
    input  logic                     ld_ack,
    output logic [DATA_LENGTH-1:0]   ld_data,
    output logic                     ld_valid,
    output logic                     ld_err
);

    localparam int SEL_W = DATA_LENGTH/8;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        LD_IDLE,
        LD_WAIT
    } ld_state_t;

    // Natural alignment check; dword only exists on a 64-bit bus.
    function automatic logic is_aligned(input logic [OFF_W-1:0] off,
                                        input logic [1:0]       size);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off[1:0] == 2'b00);
            default: ok = (DATA_LENGTH == 64) && (off == '0);
        endcase
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Store FIFO
    // ------------------------------------------------------------------
    logic [DATA_LENGTH-1:0] mem_dat [DEPTH];
    logic [SEL_W-1:0]       mem_sel [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   empty;
    logic                   full;
    logic                   st_legal;
    logic                   push_ok;
    logic                   wr_en;
    logic                   rd_en;
    logic [DATA_LENGTH-1:0] st_dat_sh;
    logic [SEL_W-1:0]       st_sel_sh;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign st_full  = full;
    assign st_count = count;
    assign st_legal = st_push && is_aligned(st_off, st_size);
    assign push_ok  = st_legal && (!full || st_ack);
    assign rd_en    = st_ack && !empty;

`ifdef WB_DATA_BUFFER_BYPASS_EN
    // An entry bypassed and acknowledged in the same cycle never lands.
    assign wr_en = push_ok && !(empty && st_ack);
`else
    assign wr_en = push_ok;
`endif

    // Lane-align the incoming store data and byte selects.
    always_comb begin
        logic [SEL_W-1:0] sel_mask;
        sel_mask  = ~({SEL_W{1'b1}} << (4'd1 << st_size));
        st_dat_sh = st_data << {st_off, 3'b000};
        st_sel_sh = sel_mask << st_off;
    end

    // FIFO storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_dat[wr_ptr] <= st_dat_sh;
            mem_sel[wr_ptr] <= st_sel_sh;
        end
    end

    // Pointers, occupancy and store status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            st_err <= 1'b0;
            st_ovf <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            st_err <= st_push && !is_aligned(st_off, st_size);
            if (st_legal && full && !st_ack) st_ovf <= 1'b1;
        end
    end

    // Head presentation; zero while empty.
    always_comb begin
        st_valid  = !empty;
        bus_dat_o = empty ? '0 : mem_dat[rd_ptr];
        bus_sel_o = empty ? '0 : mem_sel[rd_ptr];
`ifdef WB_DATA_BUFFER_BYPASS_EN
        if (empty && st_legal) begin
            st_valid  = 1'b1;
            bus_dat_o = st_dat_sh;
            bus_sel_o = st_sel_sh;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    ld_state_t              state;
    ld_state_t              state_nxt;
    logic                   ld_capture;
    logic                   ld_complete;
    logic                   ld_reject;
    logic                   ld_legal;
    logic [OFF_W-1:0]       ld_off_q;
    logic [1:0]             ld_size_q;
    logic                   ld_uns_q;
    logic [DATA_LENGTH-1:0] ld_ext;

    assign ld_legal = is_aligned(ld_off, ld_size);
    assign ld_busy  = (state == LD_WAIT);

    // Load state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LD_IDLE;
        else        state <= state_nxt;
    end

    // Next state plus capture/complete/reject strobes.
    always_comb begin
        state_nxt   = state;
        ld_capture  = 1'b0;
        ld_complete = 1'b0;
        ld_reject   = 1'b0;
        case (state)
            LD_IDLE: begin
                if (ld_start) begin
                    if (ld_legal) begin
                        ld_capture = 1'b1;
                        state_nxt  = LD_WAIT;
                    end else begin
                        ld_reject  = 1'b1;
                    end
                end
            end
            LD_WAIT: begin
                if (ld_ack) begin
                    ld_complete = 1'b1;
                    if (ld_start && ld_legal) begin
                        ld_capture = 1'b1;
                        state_nxt  = LD_WAIT;
                    end else begin
                        ld_reject  = ld_start;
                        state_nxt  = LD_IDLE;
                    end
                end
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    // Extract the addressed lane and extend it to the full bus width.
    always_comb begin
        logic [DATA_LENGTH-1:0] sh;
        logic [DATA_LENGTH-1:0] keep;
        logic [DATA_LENGTH-1:0] msb;
        logic [6:0]             nbits;
        logic                   fill;
        sh     = bus_dat_i >> {ld_off_q, 3'b000};
        nbits  = 7'd8 << ld_size_q;
        keep   = ~({DATA_LENGTH{1'b1}} << nbits);
        msb    = keep ^ (keep >> 1);
        fill   = !ld_uns_q && (|(sh & msb));
        ld_ext = (sh & keep) | ({DATA_LENGTH{fill}} & ~keep);
    end

    // Captured request attributes and registered load results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_off_q  <= '0;
            ld_size_q <= '0;
            ld_uns_q  <= 1'b0;
            ld_data   <= '0;
            ld_valid  <= 1'b0;
            ld_err    <= 1'b0;
        end else begin
            if (ld_capture) begin
                ld_off_q  <= ld_off;
                ld_size_q <= ld_size;
                ld_uns_q  <= ld_unsigned;
            end
            if (ld_complete) ld_data <= ld_ext;
            ld_valid <= ld_complete;
            ld_err   <= ld_reject;
        end
    end

endmodule

// File: tb/tb_wb_data_buffer.sv
// tb_wb_data_buffer: directed self-checking bench for wb_data_buffer
// (DATA_LENGTH=32, DEPTH=4).
module tb_wb_data_buffer;

    localparam int DL    = 32;
    localparam int DEPTH = 4;
    localparam int OFF_W = 2;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             st_push;
    logic [DL-1:0]    st_data;
    logic [OFF_W-1:0] st_off;
    logic [1:0]       st_size;
    logic             st_full;
    logic [CNT_W-1:0] st_count;
    logic             st_err;
    logic             st_ovf;
    logic             st_valid;
    logic [DL-1:0]    bus_dat_o;
    logic [DL/8-1:0]  bus_sel_o;
    logic             st_ack;
    logic             ld_start;
    logic [OFF_W-1:0] ld_off;
    logic [1:0]       ld_size;
    logic             ld_unsigned;
    logic             ld_busy;
    logic [DL-1:0]    bus_dat_i;
    logic             ld_ack;
    logic [DL-1:0]    ld_data;
    logic             ld_valid;
    logic             ld_err;

    int n_checks;
    int n_fail;

    wb_data_buffer #(.DATA_LENGTH(DL), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_push(st_push), .st_data(st_data), .st_off(st_off), .st_size(st_size),
        .st_full(st_full), .st_count(st_count), .st_err(st_err), .st_ovf(st_ovf),
        .st_valid(st_valid), .bus_dat_o(bus_dat_o), .bus_sel_o(bus_sel_o),
        .st_ack(st_ack),
        .ld_start(ld_start), .ld_off(ld_off), .ld_size(ld_size),
        .ld_unsigned(ld_unsigned), .ld_busy(ld_busy), .bus_dat_i(bus_dat_i),
        .ld_ack(ld_ack), .ld_data(ld_data), .ld_valid(ld_valid), .ld_err(ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DL-1:0] d, input logic [1:0] off,
                        input logic [1:0] sz, input logic ack);
        st_push = 1'b1; st_data = d; st_off = off; st_size = sz; st_ack = ack;
        tick();
        st_push = 1'b0; st_ack = 1'b0;
    endtask

    logic [DL-1:0] drain_exp [3];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        st_push = 0; st_data = '0; st_off = '0; st_size = '0; st_ack = 0;
        ld_start = 0; ld_off = '0; ld_size = '0; ld_unsigned = 0;
        bus_dat_i = '0; ld_ack = 0;
        #12;
        check("rst_count", 64'(st_count), 64'd0);
        check("rst_valid", 64'(st_valid), 64'd0);
        check("rst_dat_o", 64'(bus_dat_o), 64'd0);
        check("rst_busy",  64'(ld_busy), 64'd0);
        check("rst_ld_data", 64'(ld_data), 64'd0);
        check("rst_ovf", 64'(st_ovf), 64'd0);
        reset = 1'b1;
        tick();

        // Byte store into empty FIFO
        push(32'h0000_00AB, 2'd2, 2'b00, 1'b0);
        check("byte_valid", 64'(st_valid), 64'd1);
        check("byte_dat",   64'(bus_dat_o), 64'h00AB_0000);
        check("byte_sel",   64'(bus_sel_o), 64'h4);
        check("byte_count", 64'(st_count), 64'd1);
        st_ack = 1'b1; tick(); st_ack = 1'b0;
        check("pop_count", 64'(st_count), 64'd0);
        check("pop_valid", 64'(st_valid), 64'd0);
        check("empty_dat", 64'(bus_dat_o), 64'd0);
        check("empty_sel", 64'(bus_sel_o), 64'd0);
        // ack while empty ignored
        st_ack = 1'b1; tick(); st_ack = 1'b0;
        check("ack_empty_count", 64'(st_count), 64'd0);

        // Fill, overflow, full push+pop
        for (int i = 1; i <= 4; i++) push(32'h1111_1111 * i, 2'd0, 2'b10, 1'b0);
        check("full_flag",  64'(st_full), 64'd1);
        check("full_count", 64'(st_count), 64'd4);
        check("full_ovf0",  64'(st_ovf), 64'd0);
        check("full_sel",   64'(bus_sel_o), 64'hF);
        push(32'h5555_5555, 2'd0, 2'b10, 1'b0);
        check("ovf_count", 64'(st_count), 64'd4);
        check("ovf_set",   64'(st_ovf), 64'd1);
        check("ovf_head",  64'(bus_dat_o), 64'h1111_1111);
        push(32'h6666_6666, 2'd0, 2'b10, 1'b1);
        check("pp_count", 64'(st_count), 64'd4);
        check("pp_head",  64'(bus_dat_o), 64'h2222_2222);
        check("pp_ovf",   64'(st_ovf), 64'd1);
        drain_exp[0] = 32'h3333_3333;
        drain_exp[1] = 32'h4444_4444;
        drain_exp[2] = 32'h6666_6666;
        for (int i = 0; i < 3; i++) begin
            st_ack = 1'b1; tick(); st_ack = 1'b0;
            check("drain_head", 64'(bus_dat_o), 64'(drain_exp[i]));
        end
        st_ack = 1'b1; tick(); st_ack = 1'b0;
        check("drain_count", 64'(st_count), 64'd0);
        check("drain_full",  64'(st_full), 64'd0);

        // Misaligned store and load
        push(32'h0000_BEEF, 2'd1, 2'b01, 1'b0);
        check("st_err_pulse", 64'(st_err), 64'd1);
        check("st_err_count", 64'(st_count), 64'd0);
        tick();
        check("st_err_clear", 64'(st_err), 64'd0);
        // dword illegal on a 32-bit bus
        push(32'h0000_0001, 2'd0, 2'b11, 1'b0);
        check("st_dword_err", 64'(st_err), 64'd1);
        ld_start = 1; ld_size = 2'b10; ld_off = 2'd2; tick(); ld_start = 0;
        check("ld_err_pulse", 64'(ld_err), 64'd1);
        check("ld_err_busy",  64'(ld_busy), 64'd0);
        tick();
        check("ld_err_clear", 64'(ld_err), 64'd0);

        // Signed/unsigned byte load at offset 3
        ld_start = 1; ld_size = 2'b00; ld_off = 2'd3; ld_unsigned = 0; tick(); ld_start = 0;
        check("ldb_busy", 64'(ld_busy), 64'd1);
        // ld_start in WAIT without ack is ignored
        ld_start = 1; ld_size = 2'b10; ld_off = 2'd1; tick(); ld_start = 0;
        check("wait_start_noerr", 64'(ld_err), 64'd0);
        bus_dat_i = 32'h8012_3456; ld_ack = 1; tick(); ld_ack = 0;
        check("ldb_s_data",  64'(ld_data), 64'hFFFF_FF80);
        check("ldb_s_valid", 64'(ld_valid), 64'd1);
        check("ldb_s_busy",  64'(ld_busy), 64'd0);
        tick();
        check("ldb_valid_clr", 64'(ld_valid), 64'd0);
        check("ldb_hold",      64'(ld_data), 64'hFFFF_FF80);
        ld_start = 1; ld_size = 2'b00; ld_off = 2'd3; ld_unsigned = 1; tick(); ld_start = 0;
        ld_ack = 1; tick(); ld_ack = 0;
        check("ldb_u_data", 64'(ld_data), 64'h0000_0080);
        // ack in IDLE ignored
        bus_dat_i = 32'h1234_5678; ld_ack = 1; tick(); ld_ack = 0;
        check("idle_ack_valid", 64'(ld_valid), 64'd0);
        check("idle_ack_data",  64'(ld_data), 64'h0000_0080);

        // Back-to-back loads
        ld_start = 1; ld_size = 2'b01; ld_off = 2'd2; ld_unsigned = 0; tick();
        ld_size = 2'b10; ld_off = 2'd0; bus_dat_i = 32'h7FFF_0000; ld_ack = 1; tick();
        ld_start = 0; ld_ack = 0;
        check("b2b_data1", 64'(ld_data), 64'h0000_7FFF);
        check("b2b_busy",  64'(ld_busy), 64'd1);
        check("b2b_valid", 64'(ld_valid), 64'd1);
        bus_dat_i = 32'hDEAD_BEEF; ld_ack = 1; tick(); ld_ack = 0;
        check("b2b_data2", 64'(ld_data), 64'hDEAD_BEEF);
        check("b2b_idle",  64'(ld_busy), 64'd0);

        // Asynchronous reset mid-transfer
        for (int i = 0; i < 3; i++) push(32'hA0A0_0000 + i, 2'd0, 2'b10, 1'b0);
        ld_start = 1; ld_size = 2'b10; ld_off = 2'd0; tick(); ld_start = 0;
        check("pre_rst_count", 64'(st_count), 64'd3);
        check("pre_rst_busy",  64'(ld_busy), 64'd1);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_count", 64'(st_count), 64'd0);
        check("mid_rst_valid", 64'(st_valid), 64'd0);
        check("mid_rst_dat_o", 64'(bus_dat_o), 64'd0);
        check("mid_rst_sel_o", 64'(bus_sel_o), 64'd0);
        check("mid_rst_busy",  64'(ld_busy), 64'd0);
        check("mid_rst_ldata", 64'(ld_data), 64'd0);
        check("mid_rst_ovf",   64'(st_ovf), 64'd0);
        #1 reset = 1'b1;
        bus_dat_i = 32'h1357_9BDF; ld_ack = 1; tick(); ld_ack = 0;
        check("post_rst_valid", 64'(ld_valid), 64'd0);
        check("post_rst_ldata", 64'(ld_data), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_data_buffer.md
Name: wb_data_buffer

Overview:
- Parametrised successor to the single-entry data staging register between the multicycle core and the Wishbone data port.
- Store path: DEPTH-entry FIFO holding lane-aligned write data plus byte selects.
- Load path: one outstanding request; on acknowledge, the returned bus word is captured, lane-extracted and sign/zero-extended.
- Sits between core load/store unit and Wishbone master FSM.

Parameters:
- DATA_LENGTH, 32, bus width in bits; 32 or 64 only.
- DEPTH, 4, store FIFO entries; power of 2, at least 2.
- OFF_W, $clog2(DATA_LENGTH/8), byte-offset width (derived, not overridden).
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- st_push  in  1  enqueue store request.
- st_data  in  DATA_LENGTH  store data, right-justified.
- st_off  in  OFF_W  byte offset within bus word.
- st_size  in  2  00 byte, 01 half, 10 word, 11 dword (64-bit only).
- st_full  out  1  FIFO full.
- st_count  out  CNT_W  FIFO occupancy.
- st_err  out  1  one-cycle pulse on rejected (misaligned/illegal) push.
- st_ovf  out  1  sticky; push while full and not popping.
- st_valid  out  1  FIFO head valid (non-empty).
- bus_dat_o  out  DATA_LENGTH  head data, lane-shifted.
- bus_sel_o  out  DATA_LENGTH/8  head byte selects.
- st_ack  in  1  bus accepted head; pop.
- ld_start  in  1  start load request.
- ld_off  in  OFF_W  load byte offset.
- ld_size  in  2  same encoding as st_size.
- ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- ld_busy  out  1  load outstanding.
- bus_dat_i  in  DATA_LENGTH  Wishbone read data.
- ld_ack  in  1  read data valid on bus_dat_i.
- ld_data  out  DATA_LENGTH  extended load result, held until next completion.
- ld_valid  out  1  one-cycle pulse on completion.
- ld_err  out  1  one-cycle pulse on rejected ld_start.

Behaviour:

Reset:
- All outputs 0, including st_count, st_ovf and ld_data.
- FIFO pointers cleared and load FSM to IDLE, asynchronously.
- Reset asserted mid-transfer discards all FIFO contents and any outstanding load; no ld_valid is produced afterwards.

Alignment:
- Half requires off[0]=0; word requires off[1:0]=0; dword requires off=0 and DATA_LENGTH=64.
- Size 11 with DATA_LENGTH=32 is illegal.
- Illegal store: not enqueued; st_err=1 for the next cycle.
- Illegal load: not started; ld_err=1 for the next cycle.

Store FIFO:
- Entry data = st_data shifted left by 8*st_off.
- Entry sel = size mask (1, 3, F, FF) shifted left by st_off.
- Push accepted when not full, or when full and st_ack is asserted the same cycle.
- Push while full without st_ack: dropped; st_ovf is set and stays set until reset.
- Pop on st_ack && st_valid; st_ack while empty is ignored.
- Simultaneous push and pop: count unchanged.
- Latency: pushed entry visible on bus_dat_o/bus_sel_o/st_valid the cycle after the push edge.
- bus_dat_o and bus_sel_o read 0 while empty.
- Pointers wrap modulo DEPTH; st_full = (count==DEPTH).

Load FSM (IDLE, WAIT):
- IDLE + legal ld_start: capture off/size/unsigned, go to WAIT; ld_busy=1.
- WAIT + ld_ack:
  - ld_data <= (bus_dat_i >> 8*off), truncated to size, then sign- or zero-extended to DATA_LENGTH.
  - ld_valid pulses one cycle.
  - Return to IDLE, unless ld_start is asserted the same cycle (back-to-back): then the new request is captured and the FSM stays in WAIT.
- ld_start in WAIT without ld_ack: ignored (no ld_err).
- ld_ack in IDLE: ignored; ld_data unchanged.
- Store and load paths are fully independent.

Optional Feature:
- Macro: WB_DATA_BUFFER_BYPASS_EN.
- Defined:
  - When FIFO is empty and a legal st_push occurs, st_valid/bus_dat_o/bus_sel_o reflect the incoming entry combinationally in the same cycle.
  - If st_ack is also asserted that cycle, the entry is not written and count stays 0.
- Undefined: strict one-cycle push-to-head latency as above.

Test Plan:
- Push byte st_data=0x000000AB, off=2 into empty FIFO -> next cycle st_valid=1, bus_dat_o=0x00AB0000, bus_sel_o=0100, st_count=1.
- Push 4 words without st_ack (DEPTH=4), then 5th push -> st_full=1, st_count=4, st_ovf=1; then push+st_ack same cycle -> accepted, count stays 4, head advances to entry 2.
- Push half with off=1 -> st_err pulse, st_count unchanged; ld_start word off=2 -> ld_err pulse, ld_busy=0.
- ld_start byte off=3 signed, bus_dat_i=0x80123456 with ld_ack -> ld_data=0xFFFFFF80, ld_valid one cycle; repeat with ld_unsigned=1 -> 0x00000080.
- ld_start half off=2 signed, then ld_ack + ld_start (word, off 0) same cycle with bus_dat_i=0x7FFF0000 -> ld_data=0x00007FFF, ld_busy stays 1; next ld_ack with 0xDEADBEEF -> ld_data=0xDEADBEEF.
- Reset low while FIFO has 3 entries and a load is in WAIT -> all outputs 0 immediately, st_count=0; a subsequent ld_ack produces no ld_valid.
